// File: rtl/psx_poll_sched.sv
// PSX controller-bus frame scheduler: on each poll tick, polls port 0 then port 1
// through the shared byte shifter and latches buttons/presence per port.
module psx_poll_sched #(
  parameter int unsigned POLL_PERIOD = 117,
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter int unsigned ATT_SETUP   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_byte_start,
  output logic [7:0]  o_byte_tx,
  input  logic        i_byte_done,
  input  logic [7:0]  i_byte_rx,
  input  logic        i_ack_seen,
  output logic [1:0]  o_att_n,
  output logic [15:0] o_buttons_p0,
  output logic [15:0] o_buttons_p1,
  output logic [1:0]  o_present,
  output logic [1:0]  o_valid,
  output logic        o_frame_done,
  output logic        o_poll_overrun
);

  localparam int unsigned PER_W   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > ATT_SETUP) ? ACK_TIMEOUT : ATT_SETUP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NBYTES  = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_ACKWAIT, S_FINISH, S_GAP
  } state_t;

  state_t           r_state, w_state_nx;
  logic [PER_W-1:0] r_period;
  logic             w_tick;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx, w_idx_inc;
  logic             r_port, w_port_nx;
  logic [1:0]       r_att_n, w_att_n_nx;
  logic             r_byte_start, w_byte_start_nx;
  logic [7:0]       r_byte_tx, w_byte_tx_nx;
  logic [7:0]       r_rx2, w_rx2_nx;
  logic [7:0]       r_rx3, w_rx3_nx;
  logic [15:0]      r_buttons0, w_buttons0_nx;
  logic [15:0]      r_buttons1, w_buttons1_nx;
  logic [1:0]       r_present, w_present_nx;
  logic [1:0]       r_valid, w_valid_nx;
  logic             r_frame_done, w_frame_done_nx;
  logic             r_poll_overrun, w_poll_overrun_nx;
  logic             w_fin, w_ok;

  function automatic logic [7:0] f_poll_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    f_poll_byte = 8'h01;
      3'd1:    f_poll_byte = 8'h42;
      default: f_poll_byte = 8'h00;
    endcase
  endfunction

  // Free-running poll period counter; the tick is its wrap cycle.
  assign w_tick = (r_period == PER_W'(POLL_PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_period <= '0;
    else if (w_tick) r_period <= '0;
    else             r_period <= r_period + PER_W'(1);
  end

  assign w_idx_inc = r_idx + IDX_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx        = r_state;
    w_cnt_nx          = r_cnt;
    w_idx_nx          = r_idx;
    w_port_nx         = r_port;
    w_att_n_nx        = r_att_n;
    w_byte_start_nx   = 1'b0;
    w_byte_tx_nx      = r_byte_tx;
    w_rx2_nx          = r_rx2;
    w_rx3_nx          = r_rx3;
    w_buttons0_nx     = r_buttons0;
    w_buttons1_nx     = r_buttons1;
    w_present_nx      = r_present;
    w_valid_nx        = 2'b00;
    w_frame_done_nx   = 1'b0;
    w_poll_overrun_nx = w_tick && (r_state != S_IDLE);
    w_fin             = 1'b0;
    w_ok              = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_tick && i_enable) begin
          w_port_nx  = 1'b0;
          w_att_n_nx = 2'b10;
          w_cnt_nx   = '0;
          w_state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(ATT_SETUP - 1)) begin
          w_idx_nx        = '0;
          w_byte_start_nx = 1'b1;
          w_byte_tx_nx    = f_poll_byte('0);
          w_state_nx      = S_SEND;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (i_byte_done) begin
          if (r_idx == IDX_W'(2)) w_rx2_nx = i_byte_rx;
          if (r_idx == IDX_W'(3)) w_rx3_nx = i_byte_rx;
          if (r_idx == IDX_W'(NBYTES - 1)) begin
            w_fin = 1'b1;
            w_ok  = (r_rx2 == 8'h5A);
          end else if (i_ack_seen) begin
            w_idx_nx        = w_idx_inc;
            w_byte_start_nx = 1'b1;
            w_byte_tx_nx    = f_poll_byte(w_idx_inc);
          end else begin
            w_cnt_nx   = CNT_W'(1);
            w_state_nx = S_ACKWAIT;
          end
        end
      end
      S_ACKWAIT: begin
        if (i_ack_seen) begin
          w_idx_nx        = w_idx_inc;
          w_byte_start_nx = 1'b1;
          w_byte_tx_nx    = f_poll_byte(w_idx_inc);
          w_state_nx      = S_SEND;
        end else if (r_cnt == CNT_W'(ACK_TIMEOUT)) begin
          w_fin = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        // The finish cycle already counts as the first inter-port gap cycle.
        if (r_frame_done) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx   = CNT_W'(1);
          w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt >= CNT_W'(ATT_SETUP - 1)) begin
          w_port_nx  = 1'b1;
          w_att_n_nx = 2'b01;
          w_cnt_nx   = '0;
          w_state_nx = S_SETUP;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // Transaction end: results become visible in the same cycle FINISH is entered.
    if (w_fin) begin
      w_state_nx      = S_FINISH;
      w_att_n_nx      = 2'b11;
      w_valid_nx      = r_port ? 2'b10 : 2'b01;
      w_frame_done_nx = r_port || !i_enable;
      if (!r_port) begin
        w_buttons0_nx   = w_ok ? {i_byte_rx, r_rx3} : 16'hFFFF;
        w_present_nx[0] = w_ok;
      end else begin
        w_buttons1_nx   = w_ok ? {i_byte_rx, r_rx3} : 16'hFFFF;
        w_present_nx[1] = w_ok;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_port         <= 1'b0;
      r_att_n        <= 2'b11;
      r_byte_start   <= 1'b0;
      r_byte_tx      <= 8'hFF;
      r_rx2          <= 8'h00;
      r_rx3          <= 8'h00;
      r_buttons0     <= 16'hFFFF;
      r_buttons1     <= 16'hFFFF;
      r_present      <= 2'b00;
      r_valid        <= 2'b00;
      r_frame_done   <= 1'b0;
      r_poll_overrun <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_idx          <= w_idx_nx;
      r_port         <= w_port_nx;
      r_att_n        <= w_att_n_nx;
      r_byte_start   <= w_byte_start_nx;
      r_byte_tx      <= w_byte_tx_nx;
      r_rx2          <= w_rx2_nx;
      r_rx3          <= w_rx3_nx;
      r_buttons0     <= w_buttons0_nx;
      r_buttons1     <= w_buttons1_nx;
      r_present      <= w_present_nx;
      r_valid        <= w_valid_nx;
      r_frame_done   <= w_frame_done_nx;
      r_poll_overrun <= w_poll_overrun_nx;
    end
  end

  assign o_byte_start   = r_byte_start;
  assign o_byte_tx      = r_byte_tx;
  assign o_att_n        = r_att_n;
  assign o_buttons_p0   = r_buttons0;
  assign o_buttons_p1   = r_buttons1;
  assign o_present      = r_present;
  assign o_valid        = r_valid;
  assign o_frame_done   = r_frame_done;
  assign o_poll_overrun = r_poll_overrun;

endmodule

// File: tb/tb_psx_poll_sched.sv
// Bench for psx_poll_sched: modelled byte shifter/controller plus a scoreboard of
// expected per-port results checked whenever the DUT pulses valid.
module tb_psx_poll_sched;

  localparam int unsigned POLL_PERIOD = 117;
  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned ATT_SETUP   = 2;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic        byte_start, byte_done, ack_seen;
  logic [7:0]  byte_tx, byte_rx;
  logic [1:0]  att_n, present, valid;
  logic [15:0] buttons_p0, buttons_p1;
  logic        frame_done, poll_overrun;

  always #5 clk = ~clk;

  psx_poll_sched #(
    .POLL_PERIOD(POLL_PERIOD), .ACK_TIMEOUT(ACK_TIMEOUT), .ATT_SETUP(ATT_SETUP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable),
    .o_byte_start(byte_start), .o_byte_tx(byte_tx),
    .i_byte_done(byte_done), .i_byte_rx(byte_rx), .i_ack_seen(ack_seen),
    .o_att_n(att_n), .o_buttons_p0(buttons_p0), .o_buttons_p1(buttons_p1),
    .o_present(present), .o_valid(valid), .o_frame_done(frame_done),
    .o_poll_overrun(poll_overrun)
  );

  typedef struct {
    logic [1:0]  v;
    logic [15:0] b0;
    logic [15:0] b1;
    logic [1:0]  p;
    logic        fd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0] poll_bytes [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
  logic [7:0] good_rx    [5] = '{8'hFF, 8'h41, 8'h5A, 8'hFB, 8'hFF};
  logic [7:0] rx_tab  [2][5];
  int         ack_tab [2][5];
  int         done_dly = 2;

  int last_done_cyc = 0, last_ack_cyc = 0;
  int fd_cnt = 0, ovr_cnt = 0, fall0_cnt = 0;
  int fall0 = 0, prev_fall0 = 0, valid_cyc = 0;
  logic both_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [15:0] b0, input logic [15:0] b1,
                      input logic [1:0] p, input logic fd, input int lat);
    exp_t e;
    e.v = v; e.b0 = b0; e.b1 = b1; e.p = p; e.fd = fd; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_defaults();
    done_dly = 2;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 5; i++) begin
        rx_tab[p][i]  = good_rx[i];
        ack_tab[p][i] = (i < 4) ? 1 : -1;
      end
  endtask

  task automatic wait_frame(input int target, input string name);
    int n;
    n = 0;
    while (fd_cnt < target && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(fd_cnt), 32'(target));
    @(negedge clk);
  endtask

  task automatic wait_att(input logic [1:0] pat, input string name);
    int n;
    n = 0;
    while (att_n !== pat && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(att_n), 32'(pat));
  endtask

  // Byte shifter + controller model.
  initial begin : responder
    int bidx, cur_port, cur_idx, pend, ackc, k;
    bidx = 0; cur_port = 0; cur_idx = 0; pend = 0; ackc = 0; k = 0;
    byte_done = 1'b0; ack_seen = 1'b0; byte_rx = 8'h00;
    forever begin
      @(negedge clk);
      byte_done = 1'b0;
      ack_seen  = 1'b0;
      if (att_n == 2'b11) bidx = 0;
      if (ackc > 0) begin
        ackc--;
        if (ackc == 0) begin ack_seen = 1'b1; last_ack_cyc = cyc; end
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          byte_done = 1'b1;
          byte_rx = rx_tab[cur_port][cur_idx];
          last_done_cyc = cyc;
          k = ack_tab[cur_port][cur_idx];
          if (k == 0) begin ack_seen = 1'b1; last_ack_cyc = cyc; end
          else if (k > 0) ackc = k;
        end
      end
      if (byte_start) begin
        if (bidx < 5) begin
          cur_port = (att_n == 2'b01) ? 1 : 0;
          cur_idx  = bidx;
          chk("byte_tx", 32'(byte_tx), 32'(poll_bytes[bidx]));
          if (bidx > 0) chk("ack_to_start", 32'(cyc), 32'(last_ack_cyc + 1));
          bidx++;
          pend = done_dly;
        end else begin
          checks++;
          errors++;
          $display("FAIL byte_count: got byte_start number %0d, at most 5 allowed", bidx + 1);
        end
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin : monitor
    logic [1:0] prev_att;
    logic       arm;
    int         arm_cyc;
    exp_t       e;
    prev_att = 2'b11; arm = 1'b0; arm_cyc = 0;
    forever begin
      @(negedge clk);
      if (att_n === 2'b00) both_low = 1'b1;
      if (poll_overrun === 1'b1) ovr_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
      if (prev_att[0] === 1'b1 && att_n[0] === 1'b0) begin
        prev_fall0 = fall0; fall0 = cyc; fall0_cnt++; arm = 1'b1; arm_cyc = cyc;
      end
      if (prev_att[1] === 1'b1 && att_n[1] === 1'b0) begin
        chk("gap_len", 32'(cyc - valid_cyc), 32'(ATT_SETUP));
        arm = 1'b1; arm_cyc = cyc;
      end
      if (byte_start === 1'b1 && arm) begin
        arm = 1'b0;
        chk("setup_len", 32'(cyc - arm_cyc), 32'(ATT_SETUP));
      end
      if (valid !== 2'b00) begin
        valid_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid=%b with no result outstanding", valid);
        end else begin
          e = sb.pop_front();
          chk("valid", 32'(valid), 32'(e.v));
          chk("buttons_p0", 32'(buttons_p0), 32'(e.b0));
          chk("buttons_p1", 32'(buttons_p1), 32'(e.b1));
          chk("present", 32'(present), 32'(e.p));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          chk("valid_latency", 32'(cyc - last_done_cyc), 32'(e.lat));
          chk("att_n_at_valid", 32'(att_n), 32'(2'b11));
        end
      end else if (frame_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done: got frame_done=1 with valid=00");
      end
      prev_att = att_n;
    end
  end

  initial begin : stimulus
    int rel_cyc, bs, n, f0;
    rst = 1'b1; enable = 1'b0;
    set_defaults();
    repeat (3) @(negedge clk);
    chk("rst_att_n", 32'(att_n), 32'(2'b11));
    chk("rst_byte_start", 32'(byte_start), 32'(0));
    chk("rst_byte_tx", 32'(byte_tx), 32'(8'hFF));
    chk("rst_buttons", 32'({buttons_p0, buttons_p1}), 32'hFFFF_FFFF);
    chk("rst_present", 32'(present), 32'(0));
    chk("rst_pulses", 32'({valid, frame_done, poll_overrun}), 32'(0));
    rel_cyc = cyc; rst = 1'b0; enable = 1'b1;

    // Two good ports.
    push(2'b01, 16'hFFFB, 16'hFFFF, 2'b01, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFB, 2'b11, 1'b1, 1);
    wait_frame(1, "t1_frame");
    chk("first_tick", 32'(fall0 - rel_cyc), 32'(POLL_PERIOD));

    // Port 1 never acks byte 0.
    for (int i = 0; i < 5; i++) ack_tab[1][i] = -1;
    push(2'b01, 16'hFFFB, 16'hFFFB, 2'b11, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFF, 2'b01, 1'b1, ACK_TIMEOUT + 1);
    wait_frame(2, "t2_frame");
    chk("poll_period", 32'(fall0 - prev_fall0), 32'(POLL_PERIOD));

    // Port 0 returns a bad 0x5A marker.
    set_defaults();
    rx_tab[0][2] = 8'h00;
    push(2'b01, 16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 1);
    push(2'b10, 16'hFFFF, 16'hFFFB, 2'b10, 1'b1, 1);
    wait_frame(3, "t3_frame");

    // Ack coincident with byte_done; ack exactly at the timeout limit.
    set_defaults();
    for (int i = 0; i < 4; i++) ack_tab[0][i] = 0;
    ack_tab[1][0] = ACK_TIMEOUT;
    push(2'b01, 16'hFFFB, 16'hFFFB, 2'b11, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFB, 2'b11, 1'b1, 1);
    wait_frame(4, "t4_frame");

    // Ack one cycle too late.
    set_defaults();
    ack_tab[1][0] = ACK_TIMEOUT + 1;
    push(2'b01, 16'hFFFB, 16'hFFFB, 2'b11, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFF, 2'b01, 1'b1, ACK_TIMEOUT + 1);
    wait_frame(5, "t5_frame");
    chk("no_overrun_yet", 32'(ovr_cnt), 32'(0));

    // Slow shifter stretches the frame past one poll period.
    set_defaults();
    done_dly = 12;
    push(2'b01, 16'hFFFB, 16'hFFFF, 2'b01, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFB, 2'b11, 1'b1, 1);
    wait_frame(6, "t6_frame");
    chk("overrun_count", 32'(ovr_cnt), 32'(1));
    set_defaults();

    // Reset while port 0 byte 2 is on the wire.
    wait_att(2'b10, "t7_att0_low");
    bs = 0; n = 0;
    while (bs < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (byte_start === 1'b1) bs++;
    end
    chk("t7_reached_byte2", 32'(bs), 32'(3));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_att_n", 32'(att_n), 32'(2'b11));
    chk("midrst_buttons", 32'({buttons_p0, buttons_p1}), 32'hFFFF_FFFF);
    chk("midrst_present", 32'(present), 32'(0));
    rel_cyc = cyc; rst = 1'b0;
    push(2'b01, 16'hFFFB, 16'hFFFF, 2'b01, 1'b0, 1);
    push(2'b10, 16'hFFFB, 16'hFFFB, 2'b11, 1'b1, 1);
    wait_frame(7, "t7_frame");
    chk("restart_tick", 32'(fall0 - rel_cyc), 32'(POLL_PERIOD));

    // enable drops during port 0: frame ends after port 0, no new frames.
    wait_att(2'b10, "t8_att0_low");
    enable = 1'b0;
    push(2'b01, 16'hFFFB, 16'hFFFB, 2'b11, 1'b1, 1);
    wait_frame(8, "t8_frame");
    f0 = fall0_cnt;
    repeat (300) @(negedge clk);
    chk("disabled_no_frames", 32'(fall0_cnt), 32'(f0));
    chk("overrun_total", 32'(ovr_cnt), 32'(1));
    chk("att_never_both_low", 32'(both_low), 32'(0));
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
